// File: rtl/my_counter_checker.sv
// Receive-side monitor for the 7-state T-flip-flop sequence counter.
// Follows the code stream {Q_A,Q_B,Q_C} and decodes each code to its position
// in the cycle. It declares lock after LOCK_N consecutive legal transitions,
// then flags and counts illegal transitions while locked.
module my_counter_checker #(
  parameter int ERR_W  = 8,
  parameter int LOCK_N = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             Q_A,
  input  logic             Q_B,
  input  logic             Q_C,
  output logic             locked,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt,
  output logic [2:0]       idx,
  output logic             wrap
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // Legal successor of a code. 000 is an entry code only and is never returned.
  function automatic logic [2:0] nxt_code(input logic [2:0] c);
    case (c)
      3'b000:  return 3'b011;
      3'b011:  return 3'b111;
      3'b111:  return 3'b101;
      3'b101:  return 3'b001;
      3'b001:  return 3'b100;
      3'b100:  return 3'b110;
      3'b110:  return 3'b010;
      default: return 3'b011;  // 010 closes the cycle
    endcase
  endfunction

  // Position of a code in the cycle. The entry code 000 maps to 7.
  function automatic logic [2:0] decode_idx(input logic [2:0] c);
    case (c)
      3'b011:  return 3'd0;
      3'b111:  return 3'd1;
      3'b101:  return 3'd2;
      3'b001:  return 3'd3;
      3'b100:  return 3'd4;
      3'b110:  return 3'd5;
      3'b010:  return 3'd6;
      default: return 3'd7;
    endcase
  endfunction

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    if (&v) return v;
    return v + ERR_W'(1);
  endfunction

  logic [2:0]       code;
  logic             match;
  state_t           state_q, state_d;
  logic [3:0]       good_q, good_d;
  logic [2:0]       prev_q, prev_d;
  logic             pv_q, pv_d;
  logic [2:0]       idx_d;
  logic [ERR_W-1:0] cnt_d;
  logic             err_d, wrap_d;

  assign code  = {Q_A, Q_B, Q_C};
  assign match = (code == nxt_code(prev_q));

  // Next-state and next-output decision for one enabled sample.
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    prev_d  = prev_q;
    pv_d    = pv_q;
    idx_d   = idx;
    cnt_d   = err_cnt;
    err_d   = 1'b0;
    wrap_d  = 1'b0;
    if (en) begin
      prev_d = code;
      pv_d   = 1'b1;
      idx_d  = decode_idx(code);
      // The first sample after reset only seeds prev; nothing is checked.
      if (pv_q) begin
        case (state_q)
          HUNT: begin
            if (match) begin
              good_d  = 4'd1;
              state_d = (LOCK_N == 1) ? LOCKED : TRACK;
            end else begin
              good_d = 4'd0;
            end
          end
          TRACK: begin
            if (match) begin
              good_d = good_q + 4'd1;
              if ((good_q + 4'd1) >= 4'(LOCK_N)) state_d = LOCKED;
            end else begin
              good_d  = 4'd0;
              state_d = HUNT;
            end
          end
          LOCKED: begin
            if (match) begin
              wrap_d = (prev_q == 3'b010) && (code == 3'b011);
            end else begin
              // The bad code stays in prev, so reacquisition starts from it.
              err_d   = 1'b1;
              cnt_d   = sat_inc(err_cnt);
              good_d  = 4'd0;
              state_d = HUNT;
            end
          end
          default: begin
            good_d  = 4'd0;
            state_d = HUNT;
          end
        endcase
      end
    end
  end

  // State and output registers. locked follows the next state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= HUNT;
      good_q  <= 4'd0;
      prev_q  <= 3'b000;
      pv_q    <= 1'b0;
      locked  <= 1'b0;
      err     <= 1'b0;
      err_cnt <= '0;
      idx     <= 3'd7;
      wrap    <= 1'b0;
    end else begin
      state_q <= state_d;
      good_q  <= good_d;
      prev_q  <= prev_d;
      pv_q    <= pv_d;
      locked  <= (state_d == LOCKED);
      err     <= err_d;
      err_cnt <= cnt_d;
      idx     <= idx_d;
      wrap    <= wrap_d;
    end
  end

endmodule

// File: tb/tb_my_counter_checker.sv
// Bench for my_counter_checker. Two instances share one stimulus stream: one
// has an 8-bit error counter and one has a 2-bit error counter, which exercises
// saturation. A reference model works from cycle positions and legal run length.
module tb_my_counter_checker;

  localparam int LOCK_N = 3;

  logic       clk = 1'b0;
  logic       rst, en, q_a, q_b, q_c;
  logic       locked8, err8, wrap8, locked2, err2, wrap2;
  logic [7:0] err_cnt8;
  logic [1:0] err_cnt2;
  logic [2:0] idx8, idx2;

  my_counter_checker #(.ERR_W(8), .LOCK_N(LOCK_N)) dut8 (
    .clk(clk), .rst(rst), .en(en), .Q_A(q_a), .Q_B(q_b), .Q_C(q_c),
    .locked(locked8), .err(err8), .err_cnt(err_cnt8), .idx(idx8), .wrap(wrap8)
  );

  my_counter_checker #(.ERR_W(2), .LOCK_N(LOCK_N)) dut2 (
    .clk(clk), .rst(rst), .en(en), .Q_A(q_a), .Q_B(q_b), .Q_C(q_c),
    .locked(locked2), .err(err2), .err_cnt(err_cnt2), .idx(idx2), .wrap(wrap2)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int n_wrap = 0;
  int n_err  = 0;

  // The counter cycle in order. Position 7 stands for the entry code 000.
  logic [2:0] seq_tab [0:6] = '{3'b011, 3'b111, 3'b101, 3'b001, 3'b100, 3'b110, 3'b010};

  // Reference model state.
  bit         m_pv = 0;
  logic [2:0] m_prev = 3'b000;
  int         m_run = 0;
  int         m_idx = 7;
  int         m_cnt = 0;
  bit         m_err = 0, m_wrap = 0, m_locked = 0;

  function automatic int pos(input logic [2:0] c);
    for (int i = 0; i < 7; i++) if (seq_tab[i] == c) return i;
    return 7;
  endfunction

  function automatic logic [2:0] succ(input logic [2:0] c);
    int p;
    p = pos(c);
    if (p == 7) return 3'b011;
    return seq_tab[(p + 1) % 7];
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // The checker is locked exactly when the current run of legal transitions
  // has reached LOCK_N.
  task automatic model_step(input bit r, input bit e, input logic [2:0] c);
    bit was_locked, ok;
    m_err  = 0;
    m_wrap = 0;
    if (!r) begin
      m_pv = 0; m_run = 0; m_idx = 7; m_cnt = 0; m_locked = 0;
      return;
    end
    if (!e) return;
    m_idx = pos(c);
    if (m_pv) begin
      was_locked = (m_run >= LOCK_N);
      ok = (c == succ(m_prev));
      if (ok) begin
        if (m_run < 1000) m_run++;
        if (was_locked && m_prev == 3'b010) m_wrap = 1;
      end else begin
        if (was_locked) begin
          m_err = 1;
          m_cnt++;
        end
        m_run = 0;
      end
    end
    m_prev   = c;
    m_pv     = 1;
    m_locked = (m_run >= LOCK_N);
  endtask

  task automatic apply(input bit r, input bit e, input logic [2:0] c);
    @(negedge clk);
    rst = r; en = e; {q_a, q_b, q_c} = c;
    @(posedge clk);
    model_step(r, e, c);
    #1;
    chk("locked",   int'(locked8),  int'(m_locked));
    chk("err",      int'(err8),     int'(m_err));
    chk("err_cnt",  int'(err_cnt8), (m_cnt > 255) ? 255 : m_cnt);
    chk("idx",      int'(idx8),     m_idx);
    chk("wrap",     int'(wrap8),    int'(m_wrap));
    chk("locked2",  int'(locked2),  int'(m_locked));
    chk("err2",     int'(err2),     int'(m_err));
    chk("err_cnt2", int'(err_cnt2), (m_cnt > 3) ? 3 : m_cnt);
    chk("idx2",     int'(idx2),     m_idx);
    chk("wrap2",    int'(wrap2),    int'(m_wrap));
    if (wrap8) n_wrap++;
    if (err2)  n_err++;
  endtask

  typedef struct {
    bit         r;
    bit         e;
    logic [2:0] c;
    bit         l;
    bit         er;
    int         cnt;
    int         ix;
    bit         w;
  } vec_t;

  vec_t tbl[$];

  initial begin
    rst = 1'b0; en = 1'b0; q_a = 1'b0; q_b = 1'b0; q_c = 1'b0;

    // Reset state, lock acquisition, wrap, skip fault and relock.
    tbl.push_back('{0, 0, 3'b000, 0, 0, 0, 7, 0});
    tbl.push_back('{0, 1, 3'b011, 0, 0, 0, 7, 0});
    tbl.push_back('{1, 1, 3'b000, 0, 0, 0, 7, 0});
    tbl.push_back('{1, 1, 3'b011, 0, 0, 0, 0, 0});
    tbl.push_back('{1, 1, 3'b111, 0, 0, 0, 1, 0});
    tbl.push_back('{1, 1, 3'b101, 1, 0, 0, 2, 0});
    tbl.push_back('{1, 1, 3'b001, 1, 0, 0, 3, 0});
    tbl.push_back('{1, 1, 3'b100, 1, 0, 0, 4, 0});
    tbl.push_back('{1, 1, 3'b110, 1, 0, 0, 5, 0});
    tbl.push_back('{1, 1, 3'b010, 1, 0, 0, 6, 0});
    tbl.push_back('{1, 1, 3'b011, 1, 0, 0, 0, 1});
    tbl.push_back('{1, 1, 3'b111, 1, 0, 0, 1, 0});
    tbl.push_back('{1, 1, 3'b101, 1, 0, 0, 2, 0});
    tbl.push_back('{1, 1, 3'b100, 0, 1, 1, 4, 0});
    tbl.push_back('{1, 1, 3'b110, 0, 0, 1, 5, 0});
    tbl.push_back('{1, 1, 3'b010, 0, 0, 1, 6, 0});
    tbl.push_back('{1, 1, 3'b011, 1, 0, 1, 0, 0});

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].r, tbl[i].e, tbl[i].c);
      chk($sformatf("tbl%0d_locked", i), int'(locked8),  int'(tbl[i].l));
      chk($sformatf("tbl%0d_err", i),    int'(err8),     int'(tbl[i].er));
      chk($sformatf("tbl%0d_cnt", i),    int'(err_cnt8), tbl[i].cnt);
      chk($sformatf("tbl%0d_idx", i),    int'(idx8),     tbl[i].ix);
      chk($sformatf("tbl%0d_wrap", i),   int'(wrap8),    int'(tbl[i].w));
    end

    // Twenty-one further legal samples from 011 complete three full cycles.
    n_wrap = 0;
    for (int i = 0; i < 21; i++) apply(1, 1, succ(m_prev));
    chk("wrap_count", n_wrap, 3);
    chk("wrap_locked", int'(locked8), 1);

    // Enable gap while locked: idx and lock hold, and no check is made.
    apply(1, 1, 3'b111);
    apply(1, 1, 3'b101);
    apply(1, 1, 3'b001);
    for (int i = 0; i < 5; i++) begin
      apply(1, 0, 3'b001);
      chk("gap_idx", int'(idx8), 3);
      chk("gap_locked", int'(locked8), 1);
    end
    apply(1, 1, 3'b100);
    chk("resume_err", int'(err8), 0);
    chk("resume_idx", int'(idx8), 4);
    chk("resume_locked", int'(locked8), 1);

    // Five faults with relock in between. The 2-bit counter saturates at 3.
    n_err = 0;
    for (int k = 0; k < 5; k++) begin
      apply(1, 1, m_prev);
      for (int j = 0; j < LOCK_N; j++) apply(1, 1, succ(m_prev));
    end
    chk("sat_err_pulses", n_err, 5);
    chk("sat_cnt2", int'(err_cnt2), 3);
    chk("sat_cnt8", int'(err_cnt8), 6);

    // Reset while locked with en=1. The first sample after reset is not checked.
    apply(0, 1, succ(m_prev));
    chk("rst_locked", int'(locked8), 0);
    chk("rst_cnt", int'(err_cnt8), 0);
    chk("rst_idx", int'(idx8), 7);
    apply(1, 1, 3'b110);
    chk("post_rst_err", int'(err8), 0);
    apply(1, 1, 3'b110);
    chk("post_rst_err2", int'(err8), 0);

    // Randomized traffic, mostly legal, with occasional faults, gaps and resets.
    for (int i = 0; i < 600; i++) begin
      bit         r, e;
      logic [2:0] c;
      r = ($urandom_range(0, 59) != 0);
      e = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 9) < 8) ? succ(m_prev) : 3'($urandom_range(0, 7));
      apply(r, e, c);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
